// File: rtl/side_buffer.sv
// side_buffer: holds flits that lost port allocation and re-injects the oldest
// one whenever the router stage reports an empty slot. A starvation counter
// raises redirect when the head flit stays blocked for too long.
module side_buffer #(
   parameter int WIDTH     = 64,
   parameter int DEPTH     = 4,
   parameter int STARVE_TH = 8,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_flit,
   output logic             in_ready,
   input  logic             slot_free,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_flit,
   output logic             redirect,
   output logic [CW-1:0]    count,
   output logic             drop_err
);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    scnt_q, scnt_d;
   logic          drop_err_q, drop_err_d;
   logic          push, pop;

   // Status flags come straight from registered state, so no input reaches
   // an output combinationally (and a fresh push is never bypassed).
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign out_flit  = mem[rp_q];
   assign redirect  = (scnt_q == 8'(STARVE_TH));
   assign count     = count_q;
   assign drop_err  = drop_err_q;

   // Next-state for pointers, occupancy, starvation counter and drop flag.
   always_comb begin
      push       = in_valid & in_ready;
      pop        = out_valid & slot_free;
      wp_d       = push ? wp_q + AW'(1) : wp_q;
      rp_d       = pop  ? rp_q + AW'(1) : rp_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      drop_err_d = drop_err_q | (in_valid & ~in_ready);
      scnt_d     = scnt_q;
      if (pop || (count_q == '0))
         scnt_d = '0;
      else if (!slot_free && (scnt_q != 8'(STARVE_TH)))
         scnt_d = scnt_q + 8'd1;
   end

   // Control state; synchronous reset discards everything buffered.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         scnt_q     <= '0;
         drop_err_q <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         scnt_q     <= scnt_d;
         drop_err_q <= drop_err_d;
      end
   end

   // Flit storage is intentionally left unreset; count gates its visibility.
   always_ff @(posedge clk) begin
      if (!reset && push)
         mem[wp_q] <= in_flit;
   end

endmodule

// File: tb/tb_side_buffer.sv
// Bench for side_buffer: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a queue-based model.
module tb_side_buffer;
   localparam int WIDTH = 64;
   localparam int DEPTH = 4;
   localparam int TH    = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset, in_valid, slot_free;
   logic [WIDTH-1:0] in_flit;
   logic             in_ready, out_valid, redirect, drop_err;
   logic [WIDTH-1:0] out_flit;
   logic [CW-1:0]    count;

   side_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_TH(TH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit),
      .in_ready(in_ready), .slot_free(slot_free), .out_valid(out_valid),
      .out_flit(out_flit), .redirect(redirect), .count(count),
      .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO of flits, sticky drop flag, and a count of consecutive
   // cycles the head has been present without a free slot.
   logic [WIDTH-1:0] q[$];
   bit               m_drop = 1'b0;
   int               m_blk  = 0;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_drop = 1'b0;
         m_blk  = 0;
      end else begin
         automatic bit full = (q.size() == DEPTH);
         automatic bit do_push = in_valid && !full;
         automatic bit do_pop  = (q.size() > 0) && slot_free;
         if (in_valid && full) m_drop = 1'b1;
         if (do_pop || q.size() == 0) m_blk = 0;
         else m_blk++;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(in_flit);
      end
   end

   // Every cycle after reset, all outputs must agree with the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",     64'(count),     64'(q.size()));
         chk("in_ready",  64'(in_ready),  64'(q.size() < DEPTH));
         chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("redirect",  64'(redirect),  64'(m_blk >= TH));
         chk("drop_err",  64'(drop_err),  64'(m_drop));
         if (q.size() > 0) chk("out_flit", out_flit, q[0]);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic push1(input logic [WIDTH-1:0] d);
      in_valid = 1'b1;
      in_flit  = d;
      cyc();
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; slot_free = 1'b0; in_flit = '0;
      cyc(); cyc();
      chk_en = 1'b1;
      reset = 1'b0;
      cyc();
      // reset values
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_redirect", 64'(redirect), 64'd0);
      chk("rst_drop_err", 64'(drop_err), 64'd0);

      // two flits, in-order pop
      push1(64'hA1); push1(64'hA2);
      chk("t1_count", 64'(count), 64'd2);
      chk("t1_head", out_flit, 64'hA1);
      slot_free = 1'b1; cyc();
      chk("t1_head2", out_flit, 64'hA2);
      chk("t1_count1", 64'(count), 64'd1);
      cyc();
      chk("t1_empty", 64'(out_valid), 64'd0);
      slot_free = 1'b0;

      // fill, overflow, drain
      for (int i = 0; i < 4; i++) push1(64'hB0 + 64'(i));
      chk("t2_full", 64'(in_ready), 64'd0);
      push1(64'hFF);
      chk("t2_drop", 64'(drop_err), 64'd1);
      chk("t2_count", 64'(count), 64'd4);
      slot_free = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain", out_flit, 64'hB0 + 64'(i));
         cyc();
      end
      chk("t2_empty", 64'(out_valid), 64'd0);
      slot_free = 1'b0;

      // starvation: redirect exactly on the 8th blocked cycle
      push1(64'hC1);
      for (int i = 1; i <= TH; i++) begin
         cyc();
         chk("t3_redirect", 64'(redirect), 64'(i == TH));
      end
      slot_free = 1'b1; cyc();
      chk("t3_redir_clr", 64'(redirect), 64'd0);
      chk("t3_popped", 64'(out_valid), 64'd0);
      slot_free = 1'b0;

      // steady push+pop at count=2 across pointer wrap
      push1(64'hD0); push1(64'hD1);
      in_valid = 1'b1; slot_free = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_flit = 64'hD2 + 64'(k);
         cyc();
         chk("t4_count", 64'(count), 64'd2);
         chk("t4_head", out_flit, 64'hD1 + 64'(k));
      end
      in_valid = 1'b0; cyc(); cyc();
      chk("t4_empty", 64'(out_valid), 64'd0);
      slot_free = 1'b0;

      // three flits with redirect pending, then reset
      push1(64'hE0); push1(64'hE1); push1(64'hE2);
      repeat (6) cyc();
      chk("t5_redirect", 64'(redirect), 64'd1);
      reset = 1'b1; cyc(); reset = 1'b0;
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_out_valid", 64'(out_valid), 64'd0);
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_redirect0", 64'(redirect), 64'd0);
      chk("t5_drop0", 64'(drop_err), 64'd0);

      // push into empty with slot_free high: no bypass
      slot_free = 1'b1;
      push1(64'hF1);
      chk("t6_nobypass", 64'(count), 64'd1);
      chk("t6_head", out_flit, 64'hF1);
      cyc();
      chk("t6_popped", 64'(count), 64'd0);
      slot_free = 1'b0;

      // randomized traffic, router honours redirect one cycle later
      for (int n = 0; n < 3000; n++) begin
         reset     = ($urandom_range(0, 199) == 0);
         in_valid  = ($urandom_range(0, 99) < 55);
         in_flit   = {$urandom, $urandom};
         slot_free = redirect ? 1'b1 : ($urandom_range(0, 99) < 30);
         cyc();
      end
      reset = 1'b0; in_valid = 1'b0; slot_free = 1'b0;
      cyc();
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
